iter_alu: RTL and testbench
===========================

ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits; legal values 8..64, even.
REQ-002 Parameter OPERRATOR_WIDTH, default 4: opcode width in bits.
REQ-003 clk  input  1: single clock; all state changes on its rising edge.
REQ-004 rst  input  1: reset, synchronous, active-high.
REQ-005 op  input  OPERRATOR_WIDTH: operation code, sampled on accept.
REQ-006 srcdata_a  input  WIDTH: operand A, sampled on accept.
REQ-007 srcdata_b  input  WIDTH: operand B, sampled on accept.
REQ-008 in_valid  input  1: op and operands are valid.
REQ-009 in_ready  output  1: block can accept a request; accept = in_valid & in_ready.
REQ-010 result  output  WIDTH: registered result, valid while out_valid is high.
REQ-011 div_zero  output  1: DIVU/REMU had srcdata_b == 0; valid with out_valid.
REQ-012 out_valid  output  1: result is valid.
REQ-013 out_ready  input  1: consumer takes result; retire = out_valid & out_ready.

Function
REQ-014 Opcodes: ADD 0000, AND 0001, OR 0010, SLL 0011, SRL 0100, SRA 0101, SUB 0110, EQUAL 0111, LESS 1000, MOVE 1001, MUL 1010, DIVU 1011, REMU 1100; every other code yields result 0.
REQ-015 ADD, SUB: modulo 2^WIDTH; carry and borrow discarded.
REQ-016 SLL, SRL, SRA: shift A by the full unsigned value of B; for B >= WIDTH, SLL and SRL give 0 and SRA gives WIDTH copies of A[WIDTH-1].
REQ-017 SRA: signed arithmetic shift (sign fill); SRL: zero fill.
REQ-018 EQUAL: result 0 if A == B, else 1.
REQ-019 LESS: unsigned compare; result 1 if A < B, else 0.
REQ-020 MOVE: result = A.
REQ-021 MUL: unsigned; result = low WIDTH bits of A*B; computed by shift-add, one bit per cycle.
REQ-022 DIVU/REMU: unsigned restoring division, one quotient bit per cycle; DIVU returns quotient, REMU returns remainder.
REQ-023 Divide by zero: DIVU result all ones, REMU result = A, div_zero = 1; same WIDTH-cycle latency as a normal divide.
REQ-024 div_zero is 0 for every other op.
REQ-025 FSM states: IDLE, BUSY, DONE.
REQ-026 IDLE: in_ready = 1, out_valid = 0. On accept of a single-cycle op (all except MUL/DIVU/REMU), go to DONE with the result registered; out_valid is high the cycle after accept (latency 1).
REQ-027 IDLE: on accept of MUL/DIVU/REMU, go to BUSY and load the iteration counter with WIDTH.
REQ-028 BUSY: in_ready = 0; one iteration per cycle; after WIDTH iterations go to DONE. out_valid rises WIDTH+1 cycles after accept.
REQ-029 DONE: out_valid = 1 and in_ready = 0; result and div_zero are held stable until retire; on retire go to IDLE.
REQ-030 Maximum throughput: one request per 2 cycles; in_valid asserted during DONE is not accepted until the next IDLE cycle.
REQ-031 Operands and op are captured on accept; input changes after accept do not affect the result.
REQ-032 Holding out_ready low stalls the block indefinitely in DONE with no loss of data.

Reset
REQ-033 While rst = 1 at a clock edge: state goes to IDLE, out_valid = 0, in_ready = 1 after the edge, result = 0, div_zero = 0, iteration counter = 0.
REQ-034 Reset during BUSY or DONE abandons the operation; no out_valid is produced for it.
REQ-035 A request with in_valid high in the same cycle as rst is not accepted.

Structure
REQ-036 Package alu_pkg holds the opcode constants, the FSM state encoding and an is_multicycle(op) function.
REQ-037 A single sub-module iter_muldiv (parameter WIDTH) holds the shift-add and restoring-divide datapath and the counter. Its interface: start, op select, A, B in; done pulse, result, div_zero out.
REQ-038 Single-cycle ops are computed combinationally in iter_alu and registered in the result register on accept.

Verification
REQ-039 WIDTH=16: ADD 0xFFFF+0x0001 -> result 0x0000, out_valid 1 cycle after accept; SUB 0x0000-0x0001 -> 0xFFFF.
REQ-040 SRA A=0x8000, B=4 -> 0xF800; SRA A=0x8000, B=20 -> 0xFFFF; SLL A=0x0001, B=16 -> 0x0000; EQUAL 5,5 -> 0; LESS 3,0x8000 -> 1.
REQ-041 MUL 0x0123*0x0100 -> 0x2300 with out_valid exactly 17 cycles after accept; DIVU 100/7 -> 14, REMU 100/7 -> 2, div_zero 0.
REQ-042 DIVU 0x1234/0 -> 0xFFFF, div_zero 1; REMU 0x1234/0 -> 0x1234, div_zero 1.
REQ-043 Backpressure: out_ready held low 10 cycles after MUL completes -> result stable and in_ready 0 throughout; in_valid held high -> next request accepted on the cycle after retire.
REQ-044 Assert rst in the 5th BUSY cycle of DIVU -> next cycle IDLE, out_valid 0, in_ready 1; a following ADD 2+3 -> 5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: opcodes, FSM encoding, mul/div select.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD   = 4'b0000;
  localparam logic [OP_W-1:0] OP_AND   = 4'b0001;
  localparam logic [OP_W-1:0] OP_OR    = 4'b0010;
  localparam logic [OP_W-1:0] OP_SLL   = 4'b0011;
  localparam logic [OP_W-1:0] OP_SRL   = 4'b0100;
  localparam logic [OP_W-1:0] OP_SRA   = 4'b0101;
  localparam logic [OP_W-1:0] OP_SUB   = 4'b0110;
  localparam logic [OP_W-1:0] OP_EQUAL = 4'b0111;
  localparam logic [OP_W-1:0] OP_LESS  = 4'b1000;
  localparam logic [OP_W-1:0] OP_MOVE  = 4'b1001;
  localparam logic [OP_W-1:0] OP_MUL   = 4'b1010;
  localparam logic [OP_W-1:0] OP_DIVU  = 4'b1011;
  localparam logic [OP_W-1:0] OP_REMU  = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MD_MUL  = 2'd0,
    MD_DIVU = 2'd1,
    MD_REMU = 2'd2
  } md_sel_e;

  function automatic logic is_multicycle(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Bit-serial datapath: shift-add multiply and restoring divide, one bit per cycle.
module iter_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  md_sel_e          i_sel,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done_c,
  output logic [WIDTH-1:0] o_result_c,
  output logic             o_div_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    r_cnt;
  md_sel_e          r_sel;
  logic [WIDTH-1:0] r_x;    // multiplicand (shifting left) or divisor
  logic [WIDTH-1:0] r_y;    // multiplier (shifting right) or dividend becoming quotient
  logic [WIDTH-1:0] r_acc;  // product or partial remainder
  logic             r_dz;

  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_x_n;
  logic [WIDTH-1:0] w_y_n;
  logic [WIDTH-1:0] w_acc_n;

  // One iteration step; a zero divisor naturally yields all-ones quotient and remainder = A.
  always_comb begin
    w_shift = {r_acc, r_y[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, r_x});
    w_diff  = WIDTH'(w_shift - {1'b0, r_x});
    w_x_n   = r_x;
    w_y_n   = r_y;
    w_acc_n = r_acc;
    if (r_sel == MD_MUL) begin
      w_acc_n = r_acc + (r_y[0] ? r_x : '0);
      w_x_n   = r_x << 1;
      w_y_n   = r_y >> 1;
    end else begin
      w_acc_n = w_ge ? w_diff : w_shift[WIDTH-1:0];
      w_y_n   = {r_y[WIDTH-2:0], w_ge};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_sel <= MD_MUL;
      r_x   <= '0;
      r_y   <= '0;
      r_acc <= '0;
      r_dz  <= 1'b0;
    end else if (i_start) begin
      r_cnt <= CW'(WIDTH);
      r_sel <= i_sel;
      r_dz  <= (i_sel != MD_MUL) && (i_b == '0);
      r_acc <= '0;
      if (i_sel == MD_MUL) begin
        r_x <= i_a;
        r_y <= i_b;
      end else begin
        r_x <= i_b;
        r_y <= i_a;
      end
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
      r_x   <= w_x_n;
      r_y   <= w_y_n;
      r_acc <= w_acc_n;
    end
  end

  assign o_done_c   = (r_cnt == CW'(1));
  assign o_result_c = (r_sel == MD_DIVU) ? w_y_n : w_acc_n;
  assign o_div_zero = r_dz;

endmodule

// File: rtl/iter_alu.sv
// ALU with single-cycle ops and iterative MUL/DIVU/REMU behind a valid/ready handshake.
module iter_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned OPERRATOR_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [OPERRATOR_WIDTH-1:0] op,
  input  logic [WIDTH-1:0]           srcdata_a,
  input  logic [WIDTH-1:0]           srcdata_b,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           result,
  output logic                       div_zero,
  output logic                       out_valid,
  input  logic                       out_ready
);

  state_e           r_state;
  state_e           w_next;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_div_zero;

  logic [OP_W-1:0]  w_op_lo;
  logic             w_op_fits;
  logic             w_multi;
  md_sel_e          w_md_sel;
  logic [WIDTH-1:0] w_alu;
  logic             w_accept;
  logic             w_start;
  logic             w_load;
  logic             w_md_done_c;
  logic [WIDTH-1:0] w_md_result_c;
  logic             w_md_dz;

  // Codes with bits set above the defined opcode field are treated as unknown.
  assign w_op_lo   = OP_W'(op);
  assign w_op_fits = (OPERRATOR_WIDTH'(w_op_lo) == op);
  assign w_multi   = w_op_fits && is_multicycle(w_op_lo);
  assign w_md_sel  = (w_op_lo == OP_MUL)  ? MD_MUL :
                     (w_op_lo == OP_DIVU) ? MD_DIVU : MD_REMU;

  // Single-cycle results; multi-cycle and unknown codes fall to zero here.
  always_comb begin
    w_alu = '0;
    if (w_op_fits) begin
      case (w_op_lo)
        OP_ADD:   w_alu = srcdata_a + srcdata_b;
        OP_AND:   w_alu = srcdata_a & srcdata_b;
        OP_OR:    w_alu = srcdata_a | srcdata_b;
        OP_SLL:   w_alu = srcdata_a << srcdata_b;
        OP_SRL:   w_alu = srcdata_a >> srcdata_b;
        OP_SRA:   w_alu = WIDTH'($signed(srcdata_a) >>> srcdata_b);
        OP_SUB:   w_alu = srcdata_a - srcdata_b;
        OP_EQUAL: w_alu = WIDTH'(srcdata_a != srcdata_b);
        OP_LESS:  w_alu = WIDTH'(srcdata_a < srcdata_b);
        OP_MOVE:  w_alu = srcdata_a;
        default:  w_alu = '0;
      endcase
    end
  end

  iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .i_sel      (w_md_sel),
    .i_a        (srcdata_a),
    .i_b        (srcdata_b),
    .o_done_c   (w_md_done_c),
    .o_result_c (w_md_result_c),
    .o_div_zero (w_md_dz)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_load   = 1'b0;
    w_accept = in_valid && r_in_ready;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_multi) begin
            w_next  = BUSY;
            w_start = 1'b1;
          end else begin
            w_next = DONE;
            w_load = 1'b1;
          end
        end
      end
      BUSY:    if (w_md_done_c) w_next = DONE;
      DONE:    if (r_out_valid && out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Handshake flags track the next state so they come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_div_zero  <= 1'b0;
    end else begin
      r_in_ready  <= (w_next == IDLE);
      r_out_valid <= (w_next == DONE);
      if (w_load) begin
        r_result   <= w_alu;
        r_div_zero <= 1'b0;
      end else if ((r_state == BUSY) && w_md_done_c) begin
        r_result   <= w_md_result_c;
        r_div_zero <= w_md_dz;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_iter_alu.sv
// Directed self-checking bench for iter_alu at WIDTH=16.
module tb_iter_alu;

  localparam int unsigned W  = 16;
  localparam int unsigned OW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [OW-1:0] op;
  logic [W-1:0]  srcdata_a;
  logic [W-1:0]  srcdata_b;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  result;
  logic          div_zero;
  logic          out_valid;
  logic          out_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
    logic        dz;
  } vec_t;

  vec_t sv_vecs[19];
  vec_t md_vecs[10];

  iter_alu #(.WIDTH(W), .OPERRATOR_WIDTH(OW)) dut (
    .clk       (clk),
    .rst       (rst),
    .op        (op),
    .srcdata_a (srcdata_a),
    .srcdata_b (srcdata_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .div_zero  (div_zero),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Issue one request, scramble inputs after accept, wait for the result, then retire it.
  task automatic do_op(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] res, output logic dz, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    op = o; srcdata_a = a; srcdata_b = b; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 4'hF; srcdata_a = 16'hA5A5; srcdata_b = 16'h5A5A;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    res = result;
    dz  = div_zero;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; op = 4'h0; srcdata_a = 16'h0001; srcdata_b = 16'h0001;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    checks++;
    if (result !== 16'h0000 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: result=%h div_zero=%b expected 0000/0", result, div_zero);
    end
    in_valid = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_accept: out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_single_cycle();
    logic [15:0] res;
    logic        dz;
    int          lat;
    sv_vecs = '{
      '{4'h0, 16'hFFFF, 16'h0001, 16'h0000, 1'b0},
      '{4'h0, 16'h1234, 16'h1111, 16'h2345, 1'b0},
      '{4'h6, 16'h0000, 16'h0001, 16'hFFFF, 1'b0},
      '{4'h1, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0},
      '{4'h2, 16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b0},
      '{4'h3, 16'h0001, 16'h0010, 16'h0000, 1'b0},
      '{4'h3, 16'h0003, 16'h0004, 16'h0030, 1'b0},
      '{4'h4, 16'h8000, 16'h000F, 16'h0001, 1'b0},
      '{4'h4, 16'h8000, 16'h0010, 16'h0000, 1'b0},
      '{4'h5, 16'h8000, 16'h0004, 16'hF800, 1'b0},
      '{4'h5, 16'h8000, 16'h0014, 16'hFFFF, 1'b0},
      '{4'h5, 16'h4000, 16'h0014, 16'h0000, 1'b0},
      '{4'h7, 16'h0005, 16'h0005, 16'h0000, 1'b0},
      '{4'h7, 16'h0005, 16'h0006, 16'h0001, 1'b0},
      '{4'h8, 16'h0003, 16'h8000, 16'h0001, 1'b0},
      '{4'h8, 16'h8000, 16'h0003, 16'h0000, 1'b0},
      '{4'h9, 16'hBEEF, 16'h1234, 16'hBEEF, 1'b0},
      '{4'hD, 16'h1234, 16'h5678, 16'h0000, 1'b0},
      '{4'hF, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0}
    };
    foreach (sv_vecs[i]) begin
      do_op(sv_vecs[i].op, sv_vecs[i].a, sv_vecs[i].b, res, dz, lat);
      checks++;
      if (res !== sv_vecs[i].exp || dz !== 1'b0) begin
        errors++;
        $display("FAIL single[%0d] op=%h: result=%h dz=%b expected %h/0",
                 i, sv_vecs[i].op, res, dz, sv_vecs[i].exp);
      end
      checks++;
      if (lat != 1) begin
        errors++;
        $display("FAIL single_lat[%0d]: latency=%0d expected 1", i, lat);
      end
    end
  endtask

  task automatic test_muldiv();
    logic [15:0] res;
    logic        dz;
    int          lat;
    md_vecs = '{
      '{4'hA, 16'h0123, 16'h0100, 16'h2300, 1'b0},
      '{4'hA, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0},
      '{4'hA, 16'h00FF, 16'h0101, 16'hFFFF, 1'b0},
      '{4'hB, 16'h0064, 16'h0007, 16'h000E, 1'b0},
      '{4'hC, 16'h0064, 16'h0007, 16'h0002, 1'b0},
      '{4'hB, 16'h1234, 16'h0000, 16'hFFFF, 1'b1},
      '{4'hC, 16'h1234, 16'h0000, 16'h1234, 1'b1},
      '{4'hB, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0},
      '{4'hC, 16'hFFFF, 16'h0010, 16'h000F, 1'b0},
      '{4'hB, 16'h0003, 16'h0007, 16'h0000, 1'b0}
    };
    foreach (md_vecs[i]) begin
      do_op(md_vecs[i].op, md_vecs[i].a, md_vecs[i].b, res, dz, lat);
      checks++;
      if (res !== md_vecs[i].exp || dz !== md_vecs[i].dz) begin
        errors++;
        $display("FAIL muldiv[%0d] op=%h: result=%h dz=%b expected %h/%b",
                 i, md_vecs[i].op, res, dz, md_vecs[i].exp, md_vecs[i].dz);
      end
      checks++;
      if (lat != 17) begin
        errors++;
        $display("FAIL muldiv_lat[%0d]: latency=%0d expected 17", i, lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    op = 4'hA; srcdata_a = 16'h0123; srcdata_b = 16'h0100; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat != 17) begin
      errors++;
      $display("FAIL bp_lat: latency=%0d expected 17", lat);
    end
    // Next request waits while the MUL result is held.
    op = 4'h0; srcdata_a = 16'h0002; srcdata_b = 16'h0003; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (result !== 16'h2300 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: result=%h in_ready=%b out_valid=%b expected 2300/0/1",
                 c, result, in_ready, out_valid);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_retire: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== 16'h0005) begin
      errors++;
      $display("FAIL bp_next: out_valid=%b result=%h expected 1/0005", out_valid, result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_busy();
    logic [15:0] res;
    logic        dz;
    int          lat;
    bit          seen;
    op = 4'hB; srcdata_a = 16'h1234; srcdata_b = 16'h0007; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 16'h0000) begin
      errors++;
      $display("FAIL rst_busy: out_valid=%b in_ready=%b result=%h expected 0/1/0000",
               out_valid, in_ready, result);
    end
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rst_busy_abandon: out_valid seen=1 expected 0");
    end
    do_op(4'h0, 16'h0002, 16'h0003, res, dz, lat);
    checks++;
    if (res !== 16'h0005 || lat != 1) begin
      errors++;
      $display("FAIL rst_busy_add: result=%h latency=%0d expected 0005/1", res, lat);
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_muldiv();
    test_back_to_back();
    test_reset_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
